// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between the core load/store path
//   (port A) and a DMA/debug master (port B). One access is granted per
//   cycle using round-robin priority with a bounded burst, so a busy owner
//   cannot starve the other port. The memory reads asynchronously and
//   writes at posedge clk; read data is registered back to the grantee.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A request (held stable until a_gnt)
//   a_gnt                      port A access performed this cycle
//   a_rvalid/a_rdata           port A load data (one-cycle valid pulse)
//   b_*                        port B, same meaning as port A
//   mem_addr/mem_din           address / write data to memory
//   mem_read/mem_write         access strobes to memory
//   mem_dout                   asynchronous read data from memory
//
// Owner FSM
//   state | meaning
//   IDLE  | no access last cycle; ties broken by 'last'
//   OWN_A | port A got the previous grant; cnt = consecutive A grants
//   OWN_B | port B got the previous grant; cnt = consecutive B grants

module dmem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } sel_t;

    owner_t           owner;
    logic [CNT_W-1:0] cnt;
    logic             last_b;     // 1 when B was the most recent grantee
    sel_t             sel;
    logic [CNT_W-1:0] cnt_inc;

    // Grantee selection. Forced to none while reset is high so that no
    // memory access (in particular no write) happens in a reset cycle.
    always_comb begin
        sel = SEL_NONE;
        if (!reset) begin
            case (owner)
                OWN_A: begin
                    if (a_req && (!b_req || (cnt < CNT_MAX))) sel = SEL_A;
                    else if (b_req)                           sel = SEL_B;
                end
                OWN_B: begin
                    if (b_req && (!a_req || (cnt < CNT_MAX))) sel = SEL_B;
                    else if (a_req)                           sel = SEL_A;
                end
                default: begin
                    if (a_req && b_req) sel = last_b ? SEL_A : SEL_B;
                    else if (a_req)     sel = SEL_A;
                    else if (b_req)     sel = SEL_B;
                end
            endcase
        end
    end

    assign a_gnt = (sel == SEL_A);
    assign b_gnt = (sel == SEL_B);

    always_comb begin
        mem_addr  = 32'd0;
        mem_din   = 32'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (sel)
            SEL_A: begin
                mem_addr  = a_addr;
                mem_din   = a_wdata;
                mem_write = a_we;
                mem_read  = !a_we;
            end
            SEL_B: begin
                mem_addr  = b_addr;
                mem_din   = b_wdata;
                mem_write = b_we;
                mem_read  = !b_we;
            end
            default: ;
        endcase
    end

    // Saturating burst counter; saturation lets an uncontended owner keep
    // streaming while still yielding immediately once the other port asks.
    assign cnt_inc = (cnt >= CNT_MAX) ? CNT_MAX : (cnt + CNT_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= IDLE;
            cnt      <= '0;
            last_b   <= 1'b1;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= 32'd0;
            b_rdata  <= 32'd0;
        end else begin
            case (sel)
                SEL_A: begin
                    owner  <= OWN_A;
                    last_b <= 1'b0;
                    cnt    <= (owner == OWN_A) ? cnt_inc : CNT_ONE;
                end
                SEL_B: begin
                    owner  <= OWN_B;
                    last_b <= 1'b1;
                    cnt    <= (owner == OWN_B) ? cnt_inc : CNT_ONE;
                end
                default: begin
                    owner <= IDLE;
                    cnt   <= '0;
                end
            endcase

            a_rvalid <= (sel == SEL_A) && !a_we;
            b_rvalid <= (sel == SEL_B) && !b_we;
            if ((sel == SEL_A) && !a_we) a_rdata <= mem_dout;
            if ((sel == SEL_B) && !b_we) b_rdata <= mem_dout;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a small behavioural memory
//   (async read, write at posedge). Inputs change 1 ns after posedge;
//   outputs are sampled a further 1 ns later.

module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_read, mem_write;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word 0x10 is preloaded while reset is held.
    always @(posedge clk) begin
        if (reset)          mem[4] <= 32'hDEADBEEF;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_din;
    end
    assign mem_dout = mem[mem_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] exp_a;
        logic [9:0] exp_b;

        // Reset with both ports requesting writes: nothing may reach memory.
        reset = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'hFFFF0000;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h24; b_wdata = 32'h0000FFFF;
        tick(); tick();
        #1;
        chk("rst_a_gnt",     a_gnt,     0);
        chk("rst_b_gnt",     b_gnt,     0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_read",  mem_read,  0);
        chk("rst_a_rvalid",  a_rvalid,  0);
        chk("rst_b_rvalid",  b_rvalid,  0);
        chk("rst_a_rdata",   a_rdata,   0);
        chk("rst_b_rdata",   b_rdata,   0);

        reset = 1'b0;
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
        tick();

        // A reads 0x10 alone.
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        #1;
        chk("t1_a_gnt",    a_gnt,    1);
        chk("t1_b_gnt",    b_gnt,    0);
        chk("t1_mem_read", mem_read, 1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        tick();
        a_req = 1'b0;
        #1;
        chk("t1_a_rvalid",  a_rvalid, 1);
        chk("t1_a_rdata",   a_rdata,  32'hDEADBEEF);
        chk("t1_b_rvalid",  b_rvalid, 0);
        chk("t1_b_rdata",   b_rdata,  0);
        chk("t1_idle_read", mem_read, 0);
        chk("t1_idle_addr", mem_addr, 0);
        tick();
        chk("t1_rvalid_drop", a_rvalid, 0);
        chk("t1_rdata_hold",  a_rdata,  32'hDEADBEEF);

        // A writes 0x20 then reads it back the next cycle.
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h12345678;
        #1;
        chk("t2_wr_gnt",   a_gnt,     1);
        chk("t2_wr_write", mem_write, 1);
        chk("t2_wr_read",  mem_read,  0);
        chk("t2_wr_din",   mem_din,   32'h12345678);
        tick();
        a_we = 1'b0;
        #1;
        chk("t2_rd_gnt",       a_gnt,    1);
        chk("t2_rd_read",      mem_read, 1);
        chk("t2_no_wr_rvalid", a_rvalid, 0);
        tick();
        a_req = 1'b0;
        #1;
        chk("t2_rvalid", a_rvalid, 1);
        chk("t2_rdata",  a_rdata,  32'h12345678);
        tick();

        // Both request right after reset: A first (last=B), then B.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20;
        #1;
        chk("t3_first_a", a_gnt, 1);
        chk("t3_first_b", b_gnt, 0);
        tick();
        a_req = 1'b0;
        #1;
        chk("t3_second_b", b_gnt,    1);
        chk("t3_a_rvalid", a_rvalid, 1);
        chk("t3_b_rvalid", b_rvalid, 0);
        tick();
        b_req = 1'b0;
        #1;
        chk("t3_b_rvalid2", b_rvalid, 1);
        chk("t3_b_rdata",   b_rdata,  32'h12345678);
        chk("t3_a_rvalid2", a_rvalid, 0);
        tick();

        // Continuous contention from IDLE with last=B: A x4, B x4, A x2.
        exp_a = 10'b11_0000_1111;
        exp_b = 10'b00_1111_0000;
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("t4_a_gnt_%0d", i), a_gnt, exp_a[i]);
            chk($sformatf("t4_b_gnt_%0d", i), b_gnt, exp_b[i]);
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // A alone for 10 cycles; B then joins and wins at once (cnt saturated).
        a_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("t5_a_alone_%0d", i), a_gnt, 1);
            tick();
        end
        b_req = 1'b1;
        #1;
        chk("t5_b_join_gnt", b_gnt, 1);
        chk("t5_a_yield",    a_gnt, 0);
        tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // Reset during a B read; a B write presented under reset is dropped.
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h10;
        #1;
        chk("t6_b_gnt", b_gnt, 1);
        tick();
        reset = 1'b1;
        b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'hBADBAD00;
        #1;
        chk("t6_rst_b_gnt",     b_gnt,     0);
        chk("t6_rst_mem_write", mem_write, 0);
        chk("t6_rst_mem_read",  mem_read,  0);
        tick();
        reset = 1'b0;
        b_req = 1'b0; b_we = 1'b0;
        #1;
        chk("t6_b_rvalid_clr", b_rvalid, 0);
        chk("t6_b_rdata_clr",  b_rdata,  0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20;
        #1;
        chk("t6_idle_a_first", a_gnt, 1);
        chk("t6_idle_b_wait",  b_gnt, 0);
        tick();
        a_req = 1'b0;
        #1;
        chk("t6_b_gnt2", b_gnt, 1);
        tick();
        b_req = 1'b0;
        #1;
        chk("t6_b_rvalid", b_rvalid, 1);
        chk("t6_no_write", b_rdata,  32'h12345678);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory between the core load/store path (port A) and a DMA/debug master (port B).
- The memory has asynchronous read and synchronous write (write commits at posedge clk).
- The arbiter picks one access per cycle, drives the memory's addr/din/mem_read/mem_write, and registers read data back to the winning requester.
- Round-robin priority with a bounded burst, so neither requester starves.

Parameters:
MAX_BURST, 4, max consecutive grants to the current owner while the other port is requesting (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
a_req  input  1  port A access request; held with a_we/a_addr/a_wdata stable until a_gnt
a_we  input  1  port A write enable (1=store, 0=load)
a_addr  input  32  port A byte address
a_wdata  input  32  port A store data
a_gnt  output  1  port A access performed this cycle
a_rvalid  output  1  port A load data valid (one-cycle pulse)
a_rdata  output  32  port A load data
b_req  input  1  port B request (same rules as A)
b_we  input  1  port B write enable
b_addr  input  32  port B byte address
b_wdata  input  32  port B store data
b_gnt  output  1  port B access performed this cycle
b_rvalid  output  1  port B load data valid
b_rdata  output  32  port B load data
mem_addr  output  32  to memory addr
mem_din  output  32  to memory din
mem_read  output  1  to memory mem_read
mem_write  output  1  to memory mem_write
mem_dout  input  32  from memory dout (async)

Behaviour:
- Registered state: owner in {IDLE, OWN_A, OWN_B}; cnt (clog2(MAX_BURST+1) bits); last (A/B, the most recent grantee).
- Reset values: owner=IDLE, cnt=0, last=B (so A wins the first tie), a_rdata=b_rdata=0, a_rvalid=b_rvalid=0.
- While reset is high: gnt, mem_read, mem_write are all 0.
- Grantee is combinational each cycle:
  - IDLE: only one req -> that port; both -> the port != last; none -> none.
  - OWN_A: a_req && (!b_req || cnt<MAX_BURST) -> A; else b_req -> B; else none.
  - OWN_B: symmetric.
- Grant outputs: x_gnt=1 only for the grantee, never without x_req. At most one gnt per cycle.
- Memory drive:
  - mem_addr/mem_din = grantee's addr/wdata.
  - mem_write = grantee's we; mem_read = !we.
  - No grantee: all four are 0.
- Next state on grant:
  - owner <= OWN_<grantee>; last <= grantee.
  - cnt <= (grantee == current owner) ? min(cnt+1, MAX_BURST) : 1.
- Next state with no grantee: owner <= IDLE, cnt <= 0; last unchanged.
- Write latency: memory write commits at the posedge ending the grant cycle. No rvalid for writes.
- Read latency: at the posedge ending a read-grant cycle, x_rdata <= mem_dout and x_rvalid <= 1. x_rvalid drops the next cycle unless another read is granted.
- x_rdata holds its value until that port's next read completes. The other port's rdata/rvalid are never disturbed.
- Back-to-back: one access per cycle sustained. A read-after-write to the same address in the next cycle returns the new data.
- Burst cap: under continuous contention the owner gets exactly MAX_BURST consecutive grants, then the other port gets the next grant.
- No contention: cnt saturates at MAX_BURST and the owner keeps getting grants every cycle.
- Reset mid-operation: an in-flight rvalid is cleared; a write presented in the reset cycle is not performed.
- Address width: full 32 bits pass through unmodified; word alignment is the memory's concern.

Test Plan:
- Reset, then A read 0x10 alone (mem preloaded 0xDEADBEEF) -> a_gnt=1 same cycle, next cycle a_rvalid=1, a_rdata=0xDEADBEEF; b outputs stay 0.
- A write 0x20<=0x12345678, then A read 0x20 next cycle -> gnt both cycles; a_rdata=0x12345678 one cycle after the read.
- A and B both request from the first cycle after reset -> A granted first (last=B), B granted second.
- A and B request continuously, MAX_BURST=4 -> grant pattern A,A,A,A,B,B,B,B,A,...
- A alone for 10 cycles then B joins -> B granted within 4 cycles of joining (cnt saturated at 4).
- Reset asserted during a B read grant -> b_rvalid=0 next cycle, no mem_write/mem_read in the reset cycle, owner=IDLE afterward.
